logo_motion_ctrl: RTL and testbench
===================================

LOGO_MOTION_CTRL -- requirements
Module: logo_motion_ctrl

Interface
REQ-001 Parameter WIDTH_LOGO, default 80, logo width in pixels.
REQ-002 Parameter HEIGHT_LOGO, default 96, logo height in pixels.
REQ-003 Parameter X_MAX, default 560 (640-WIDTH_LOGO), right-most legal x_logo.
REQ-004 Parameter Y_MAX, default 384 (480-HEIGHT_LOGO), bottom-most legal y_logo.
REQ-005 clk  in  1  system clock; all state SHALL change on its rising edge only.
REQ-006 clr  in  1  reset, asynchronous, active-low.
REQ-007 frame_tick  in  1  one-cycle pulse at start of vertical blank.
REQ-008 inc_vel  in  1  one-cycle pulse, request faster motion.
REQ-009 dec_vel  in  1  one-cycle pulse, request slower motion.
REQ-010 pause  in  1  level; high freezes motion.
REQ-011 x_logo  out  10  logo left edge, registered.
REQ-012 y_logo  out  10  logo top edge, registered.
REQ-013 snd_req  out  1  sound request, held until acknowledged.
REQ-014 snd_code  out  2  sound code: 00 stop, 01 pong, 10 ping, 11 go.
REQ-015 snd_ack  in  1  sound player accepts current request.

Function
REQ-016 period (4 bit) = frame_ticks per motion step; inc_vel decrements it saturating at 1, dec_vel increments it saturating at 15; both in the same cycle leave it unchanged.
REQ-017 frame counter fcnt (4 bit) increments on each frame_tick while pause low; on a frame_tick with fcnt >= period-1 a step SHALL occur and fcnt SHALL clear to 0.
REQ-018 pause high: fcnt and position hold; frame_ticks ignored; speed changes still accepted.
REQ-019 FSM states IDLE, MOVE: IDLE->MOVE on step; MOVE->IDLE unconditionally after one cycle; x_logo/y_logo update at the end of MOVE (latency 2 clk from frame_tick to new position).
REQ-020 frame_tick arriving while in MOVE SHALL still be counted (fcnt increment), never dropped.
REQ-021 x step magnitude 1, y step magnitude 2; sign held in dir_x, dir_y (0 = +, 1 = -).
REQ-022 Next position computed at 11-bit signed width; result > MAX clamps to MAX, result < 0 clamps to 0; clamp or exact landing on 0/MAX toggles the corresponding direction bit.
REQ-023 Hit event: x boundary only -> pong (01); y boundary only -> ping (10); both in one step -> go (11).
REQ-024 Handshake: snd_req asserts the cycle after the event with snd_code valid; snd_code stable while snd_req high; snd_req deasserts the cycle after snd_ack is sampled high with snd_req high; snd_ack while snd_req low ignored.
REQ-025 One-entry pending slot: an event occurring while snd_req high is stored; a later pending event replaces it only if higher priority (go > ping > pong).
REQ-026 Pending event issued as a new request the cycle after snd_req deasserts; slot then clears.
REQ-027 snd_code returns to 00 whenever snd_req is low.

Reset
REQ-028 clr low asynchronously forces: x_logo=280, y_logo=192, dir_x=dir_y=0, period=4, fcnt=0, state IDLE, snd_req=0, snd_code=00, pending empty.
REQ-029 First cycle after clr released, a go (11) request SHALL be issued once.
REQ-030 clr asserted mid-MOVE or mid-handshake aborts immediately; no partial position update survives.

Verification
REQ-031 Reset release, ack go, 4 frame_ticks with period 4 -> x_logo 281, y_logo 194, two clk after 4th tick.
REQ-032 Force x_logo 559 dir +, one step -> x_logo 560, dir_x toggled, snd_req with 01; next step -> 559.
REQ-033 Position (560,384) dirs +, one step -> both clamp, snd_code 11, both dirs toggle.
REQ-034 Hold snd_ack low, generate pong then ping -> first req 01 stays, after ack req drops 1 cycle then reasserts 10.
REQ-035 6 inc_vel pulses from reset -> period 1, step every frame_tick; 20 dec_vel pulses -> period 15; inc+dec same cycle -> unchanged.
REQ-036 pause high over 10 frame_ticks -> x/y constant, fcnt constant; clr low mid-MOVE -> x_logo 280 same cycle.

Source files
------------

// File: rtl/logo_motion_ctrl.sv
// Bouncing-logo motion controller: frame-rate divided stepping, wall clamping
// and a one-deep prioritised sound-request handshake.
module logo_motion_ctrl #(
    parameter int WIDTH_LOGO  = 80,
    parameter int HEIGHT_LOGO = 96,
    parameter int X_MAX       = 640 - WIDTH_LOGO,
    parameter int Y_MAX       = 480 - HEIGHT_LOGO,
    parameter int X_INIT      = X_MAX / 2,
    parameter int Y_INIT      = Y_MAX / 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       frame_tick,
    input  logic       inc_vel,
    input  logic       dec_vel,
    input  logic       pause,
    output logic [9:0] x_logo,
    output logic [9:0] y_logo,
    output logic       snd_req,
    output logic [1:0] snd_code,
    input  logic       snd_ack
);

    typedef enum logic {IDLE, MOVE} state_t;

    localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
    localparam logic signed [10:0] YMAX_S = 11'(Y_MAX);
    localparam logic [9:0]         XMAX_U = 10'(X_MAX);
    localparam logic [9:0]         YMAX_U = 10'(Y_MAX);
    localparam logic [9:0]         X_RST  = 10'(X_INIT);
    localparam logic [9:0]         Y_RST  = 10'(Y_INIT);

    state_t            state, state_nxt;
    logic [3:0]        period, fcnt;
    logic              tick_ok, step, step_pend, upd;
    logic              dir_x, dir_y;
    logic signed [10:0] x_sum, y_sum;
    logic [9:0]        x_nxt, y_nxt;
    logic              hit_x, hit_y;
    logic              boot;
    logic [1:0]        ev_code;
    logic              ev;
    logic              pend_valid;
    logic [1:0]        pend_code;

    assign tick_ok = frame_tick && !pause;
    assign step    = tick_ok && (fcnt >= period - 4'd1);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            period <= 4'd4;
        end else if (inc_vel && !dec_vel && period > 4'd1) begin
            period <= period - 4'd1;
        end else if (dec_vel && !inc_vel && period < 4'd15) begin
            period <= period + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            fcnt <= 4'd0;
        end else if (tick_ok) begin
            fcnt <= step ? 4'd0 : fcnt + 4'd1;
        end
    end

    // A step that lands while already in MOVE is remembered for one cycle
    // so back-to-back steps each get their own MOVE pass.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            step_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            step_pend <= (state == MOVE) && step;
        end
    end

    always_comb begin
        state_nxt = state;
        upd       = 1'b0;
        case (state)
            IDLE: if (step || step_pend) state_nxt = MOVE;
            MOVE: begin
                upd       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        x_sum = $signed({1'b0, x_logo}) + (dir_x ? -11'sd1 : 11'sd1);
        y_sum = $signed({1'b0, y_logo}) + (dir_y ? -11'sd2 : 11'sd2);
        x_nxt = x_sum[9:0];
        y_nxt = y_sum[9:0];
        hit_x = 1'b0;
        hit_y = 1'b0;
        if (x_sum >= XMAX_S) begin
            x_nxt = XMAX_U;
            hit_x = 1'b1;
        end else if (x_sum <= 11'sd0) begin
            x_nxt = 10'd0;
            hit_x = 1'b1;
        end
        if (y_sum >= YMAX_S) begin
            y_nxt = YMAX_U;
            hit_y = 1'b1;
        end else if (y_sum <= 11'sd0) begin
            y_nxt = 10'd0;
            hit_y = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            x_logo <= X_RST;
            y_logo <= Y_RST;
            dir_x  <= 1'b0;
            dir_y  <= 1'b0;
        end else if (upd) begin
            x_logo <= x_nxt;
            y_logo <= y_nxt;
            if (hit_x) dir_x <= ~dir_x;
            if (hit_y) dir_y <= ~dir_y;
        end
    end

    // Sound code bit 0 marks an x wall, bit 1 a y wall, so the numeric
    // value of the code doubles as its priority (go > ping > pong).
    assign ev_code = boot ? 2'b11 : (upd ? {hit_y, hit_x} : 2'b00);
    assign ev      = |ev_code;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            boot       <= 1'b1;
            snd_req    <= 1'b0;
            snd_code   <= 2'b00;
            pend_valid <= 1'b0;
            pend_code  <= 2'b00;
        end else begin
            boot <= 1'b0;
            if (snd_req) begin
                if (ev && (!pend_valid || ev_code > pend_code)) begin
                    pend_valid <= 1'b1;
                    pend_code  <= ev_code;
                end
                if (snd_ack) begin
                    snd_req  <= 1'b0;
                    snd_code <= 2'b00;
                end
            end else if (pend_valid) begin
                snd_req    <= 1'b1;
                snd_code   <= pend_code;
                pend_valid <= ev;
                pend_code  <= ev ? ev_code : 2'b00;
            end else if (ev) begin
                snd_req  <= 1'b1;
                snd_code <= ev_code;
            end
        end
    end

endmodule

// File: tb/tb_logo_motion_ctrl.sv
// Scoreboard bench for logo_motion_ctrl: a behavioural motion/sound model
// queues expected positions and sound codes, a negedge monitor retires them.
module tb_logo_motion_ctrl;

    localparam int X_MAX = 560;
    localparam int Y_MAX = 384;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       frame_tick = 1'b0;
    logic       inc_vel = 1'b0;
    logic       dec_vel = 1'b0;
    logic       pause = 1'b0;
    logic       snd_ack = 1'b0;
    logic [9:0] x_logo, y_logo;
    logic       snd_req;
    logic [1:0] snd_code;
    logic [9:0] edge_x, edge_y;
    logic       edge_req;
    logic [1:0] edge_code;

    int vectors = 0;
    int errors  = 0;

    logic [19:0] pos_q[$];
    logic [1:0]  snd_q[$];

    int   m_x, m_y, m_period, m_fcnt, m_steps;
    logic m_dx, m_dy;
    logic [1:0] m_last_code;

    logic       mon_en = 1'b0;
    logic       hold_ack = 1'b0;
    logic [9:0] prev_x, prev_y;
    logic       prev_req = 1'b0;
    logic [1:0] cur_code = 2'b00;
    logic [19:0] exp_pos;
    logic [1:0]  exp_code;
    logic [9:0]  save_x, save_y;
    int          guard;

    logo_motion_ctrl dut (
        .clk(clk), .clr(clr), .frame_tick(frame_tick), .inc_vel(inc_vel),
        .dec_vel(dec_vel), .pause(pause), .x_logo(x_logo), .y_logo(y_logo),
        .snd_req(snd_req), .snd_code(snd_code), .snd_ack(snd_ack)
    );

    // Second instance starts parked in the bottom-right corner to exercise a
    // simultaneous two-wall clamp.
    logo_motion_ctrl #(.X_INIT(X_MAX), .Y_INIT(Y_MAX)) dut_edge (
        .clk(clk), .clr(clr), .frame_tick(frame_tick), .inc_vel(inc_vel),
        .dec_vel(dec_vel), .pause(pause), .x_logo(edge_x), .y_logo(edge_y),
        .snd_req(edge_req), .snd_code(edge_code), .snd_ack(snd_ack)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_x = 280; m_y = 192; m_dx = 1'b0; m_dy = 1'b0;
        m_period = 4; m_fcnt = 0; m_steps = 0; m_last_code = 2'b00;
        pos_q.delete();
        snd_q.delete();
    endtask

    task automatic modelStep();
        int   nx, ny;
        logic hx, hy;
        nx = m_x + (m_dx ? -1 : 1);
        ny = m_y + (m_dy ? -2 : 2);
        hx = 1'b0; hy = 1'b0;
        if (nx >= X_MAX) begin nx = X_MAX; hx = 1'b1; end
        else if (nx <= 0) begin nx = 0; hx = 1'b1; end
        if (ny >= Y_MAX) begin ny = Y_MAX; hy = 1'b1; end
        else if (ny <= 0) begin ny = 0; hy = 1'b1; end
        m_x = nx; m_y = ny;
        if (hx) m_dx = ~m_dx;
        if (hy) m_dy = ~m_dy;
        m_last_code = {hy, hx};
        m_steps++;
        pos_q.push_back({10'(m_x), 10'(m_y)});
        if (m_last_code != 2'b00) snd_q.push_back(m_last_code);
    endtask

    // Drives one cycle of pulses starting at a negedge and advances the model.
    task automatic applyStimulus(input logic tick, input logic inc, input logic dec);
        frame_tick = tick; inc_vel = inc; dec_vel = dec;
        m_last_code = 2'b00;
        if (tick && !pause) begin
            if (m_fcnt >= m_period - 1) begin
                m_fcnt = 0;
                modelStep();
            end else begin
                m_fcnt++;
            end
        end
        if (inc && !dec && m_period > 1) m_period--;
        else if (dec && !inc && m_period < 15) m_period++;
        @(negedge clk);
        frame_tick = 1'b0; inc_vel = 1'b0; dec_vel = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tickGap(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            idle(3);
        end
    endtask

    // Sound player: acknowledges every request one cycle after it appears.
    initial forever begin
        @(negedge clk);
        snd_ack = snd_req && !hold_ack && !snd_ack;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (x_logo !== prev_x || y_logo !== prev_y) begin
                if (pos_q.size() == 0) begin
                    checkOutput("pos_spurious", {12'd0, x_logo, y_logo}, {12'd0, prev_x, prev_y});
                end else begin
                    exp_pos = pos_q.pop_front();
                    checkOutput("pos", {12'd0, x_logo, y_logo}, {12'd0, exp_pos});
                end
            end
            if (snd_req && !prev_req) begin
                if (snd_q.size() == 0) begin
                    checkOutput("snd_spurious", 32'(snd_req), 32'd0);
                end else begin
                    exp_code = snd_q.pop_front();
                    cur_code = exp_code;
                    checkOutput("snd_code", 32'(snd_code), 32'(exp_code));
                end
            end else if (snd_req && snd_code !== cur_code) begin
                checkOutput("snd_stable", 32'(snd_code), 32'(cur_code));
            end
            if (!snd_req && snd_code !== 2'b00) checkOutput("snd_idle", 32'(snd_code), 32'd0);
        end
        prev_x   = x_logo;
        prev_y   = y_logo;
        prev_req = snd_req;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        modelReset();
        idle(3);
        checkOutput("rst_x", 32'(x_logo), 32'd280);
        checkOutput("rst_y", 32'(y_logo), 32'd192);
        checkOutput("rst_req", 32'(snd_req), 32'd0);
        checkOutput("rst_code", 32'(snd_code), 32'd0);
        checkOutput("edge_rst_x", 32'(edge_x), 32'd560);

        snd_q.push_back(2'b11);
        clr = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        checkOutput("boot_req", 32'(snd_req), 32'd1);
        checkOutput("boot_code", 32'(snd_code), 32'd3);
        idle(3);

        // Four ticks at the reset period give exactly one step, two clocks late.
        tickGap(3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("lat_x_hold", 32'(x_logo), 32'd280);
        @(negedge clk);
        checkOutput("step1_x", 32'(x_logo), 32'd281);
        checkOutput("step1_y", 32'(y_logo), 32'd194);
        checkOutput("edge_clamp_x", 32'(edge_x), 32'd560);
        checkOutput("edge_clamp_y", 32'(edge_y), 32'd384);
        checkOutput("edge_req", 32'(edge_req), 32'd1);
        checkOutput("edge_code", 32'(edge_code), 32'd3);
        idle(2);
        tickGap(4);
        checkOutput("edge_back_x", 32'(edge_x), 32'd559);
        checkOutput("edge_back_y", 32'(edge_y), 32'd382);

        // Speed saturation at both ends, and simultaneous inc/dec.
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        tickGap(5);
        checkOutput("fast_drain", 32'(pos_q.size()), 32'd0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        tickGap(14);
        checkOutput("slow_no_step", 32'(x_logo), 32'(m_x));
        applyStimulus(1'b0, 1'b1, 1'b1);
        tickGap(1);
        checkOutput("slow_drain", 32'(pos_q.size()), 32'd0);
        for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b1, 1'b0);

        // Back-to-back ticks at period 1: the second lands during MOVE.
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        idle(5);
        checkOutput("b2b_drain", 32'(pos_q.size()), 32'd0);

        // Pause freezes motion and the frame counter; speed changes still land.
        applyStimulus(1'b0, 1'b0, 1'b1);
        tickGap(1);
        save_x = x_logo; save_y = y_logo;
        pause = 1'b1;
        tickGap(10);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("pause_x", 32'(x_logo), 32'(save_x));
        checkOutput("pause_y", 32'(y_logo), 32'(save_y));
        pause = 1'b0;
        tickGap(1);
        checkOutput("unpause_step", 32'(x_logo), 32'(m_x));
        applyStimulus(1'b0, 1'b1, 1'b0);

        // Walk to the right wall with prompt acks.
        guard = 0;
        while (!(m_x == 559 && m_dx == 1'b0) && guard < 2000) begin
            tickGap(1);
            guard++;
        end
        checkOutput("reach_559", 32'(x_logo), 32'd559);

        // Pong held unacknowledged while a ping arrives.
        hold_ack = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("wall_x", 32'(x_logo), 32'd560);
        checkOutput("pong_req", 32'(snd_req), 32'd1);
        checkOutput("pong_code", 32'(snd_code), 32'd1);
        idle(2);
        guard = 0;
        while (m_last_code != 2'b10 && guard < 100) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            if (m_last_code != 2'b10) idle(3);
            guard++;
        end
        idle(3);
        checkOutput("held_req", 32'(snd_req), 32'd1);
        checkOutput("held_code", 32'(snd_code), 32'd1);
        hold_ack = 1'b0;
        guard = 0;
        while (snd_req && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("ack_drop", 32'(snd_req), 32'd0);
        @(negedge clk);
        checkOutput("pend_req", 32'(snd_req), 32'd1);
        checkOutput("pend_code", 32'(snd_code), 32'd2);
        idle(4);
        tickGap(1);
        checkOutput("final_drain_pos", 32'(pos_q.size()), 32'd0);
        checkOutput("final_drain_snd", 32'(snd_q.size()), 32'd0);

        // Asynchronous clear in the middle of a MOVE cycle.
        applyStimulus(1'b1, 1'b0, 1'b0);
        mon_en = 1'b0;
        clr = 1'b0;
        #1;
        checkOutput("clr_async_x", 32'(x_logo), 32'd280);
        checkOutput("clr_async_y", 32'(y_logo), 32'd192);
        @(posedge clk);
        #1;
        checkOutput("clr_hold_x", 32'(x_logo), 32'd280);
        checkOutput("clr_req", 32'(snd_req), 32'd0);
        @(negedge clk);
        clr = 1'b1;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
